// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter slice.
// Holds the architectural sizes (data width, index width, register count,
// index of the hard-wired zero register XZR) and the encoding of the
// two-requester priority state used by rr_arbiter2.
package regfile_write_arbiter_pkg;

  localparam int RF_DATA_W   = 64;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ZERO_REG = 31;

  // PRIO_EX favours requester 0 (execute), PRIO_MEM favours requester 1 (memory)
  typedef enum logic {
    PRIO_EX  = 1'b0,
    PRIO_MEM = 1'b1
  } prio_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle between the EX/MEM stages and the write arbiter.
// Each requester presents valid/reg/data and holds them until ready.
//   ex_valid/ex_reg/ex_data    execute-stage result request
//   ex_ready                   execute request granted this cycle
//   mem_valid/mem_reg/mem_data memory-stage load data request
//   mem_ready                  memory request granted this cycle
// master: the pipeline stages; slave: the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = regfile_write_arbiter_pkg::RF_DATA_W,
  parameter int ADDR_W = regfile_write_arbiter_pkg::RF_ADDR_W
);

  logic              ex_valid;
  logic [ADDR_W-1:0] ex_reg;
  logic [DATA_W-1:0] ex_data;
  logic              ex_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport master (
    output ex_valid, ex_reg, ex_data, mem_valid, mem_reg, mem_data,
    input  ex_ready, mem_ready
  );

  modport slave (
    input  ex_valid, ex_reg, ex_data, mem_valid, mem_reg, mem_data,
    output ex_ready, mem_ready
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter with a one-bit priority state.
// A lone requester is always granted without touching the state; when both
// request, the favoured one wins and the state flips to favour the other,
// so neither can wait more than one extra cycle.
//   clk, reset  clock and synchronous active-high reset (state -> PRIO_MEM)
//   clear       return the state to PRIO_MEM at the next edge
//   req[1:0]    request vector (req[0] favoured by PRIO_EX, req[1] by PRIO_MEM)
//   grant[1:0]  one-hot grant, combinational; never set without its request
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  prio_t state;
  prio_t state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= PRIO_MEM;
    else       state <= state_next;
  end

  // Grants are suppressed while reset is high so no handshake completes
  // in a cycle whose effects the reset is about to discard.
  always_comb begin
    grant      = 2'b00;
    state_next = state;
    if (!reset) begin
      if (req[0] && req[1]) begin
        if (state == PRIO_EX) begin
          grant      = 2'b01;
          state_next = PRIO_MEM;
        end else begin
          grant      = 2'b10;
          state_next = PRIO_EX;
        end
      end else if (req[0]) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end
    end
    if (clear) state_next = PRIO_MEM;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the execute and memory
// writeback paths, registers the granted write towards the regfile, and keeps
// a scoreboard of destination registers with a write still outstanding.
//   clk, reset        clock, synchronous active-high reset
//   wb                writeback request bundle (slave side)
//   alloc_valid/_reg  decode marks a destination register pending
//   flush             clears scoreboard and arbitration priority
//   busy_mask         bit i set: register i has a pending write
//   rf_write_en/_reg/_data  registered write to the regfile
// Optional build macro RF_WRITE_BYPASS_EN adds two read-bypass compares
// against the write stage (byp_reg_a/b in, byp_hit_a/b and byp_data_a/b out).
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic                clk,
  input  logic                reset,
  regfile_write_arbiter_if.slave wb,
  input  logic                alloc_valid,
  input  logic [ADDR_W-1:0]   alloc_reg,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                rf_write_en,
  output logic [ADDR_W-1:0]   rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_data
`ifdef RF_WRITE_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]   byp_reg_a,
  input  logic [ADDR_W-1:0]   byp_reg_b,
  output logic                byp_hit_a,
  output logic                byp_hit_b,
  output logic [DATA_W-1:0]   byp_data_a,
  output logic [DATA_W-1:0]   byp_data_b
`endif
);

  logic [1:0]          grant;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] busy_next;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .req   ({wb.mem_valid, wb.ex_valid}),
    .grant (grant)
  );

  assign wb.ex_ready  = grant[0];
  assign wb.mem_ready = grant[1];

  always_comb begin
    sel_reg  = wb.ex_reg;
    sel_data = wb.ex_data;
    if (grant[1]) begin
      sel_reg  = wb.mem_reg;
      sel_data = wb.mem_data;
    end
  end

  // A grant to XZR completes the handshake but produces no regfile write.
  // Index and data are held between writes; only the enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_en   <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else if (grant != 2'b00) begin
      rf_write_en   <= (sel_reg != ADDR_W'(ZERO_REG));
      rf_write_reg  <= sel_reg;
      rf_write_data <= sel_data;
    end else begin
      rf_write_en   <= 1'b0;
    end
  end

  // Set is applied after clear so a newer producer allocated in the same
  // cycle keeps the register busy; flush discards both.
  always_comb begin
    busy_next = busy_mask;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rf_write_en && (rf_write_reg == ADDR_W'(i))) busy_next[i] = 1'b0;
      if (alloc_valid && (alloc_reg == ADDR_W'(i)))    busy_next[i] = 1'b1;
    end
    busy_next[ZERO_REG] = 1'b0;
    if (flush) busy_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_mask <= '0;
    else       busy_mask <= busy_next;
  end

`ifdef RF_WRITE_BYPASS_EN
  // The regfile's registered read misses a write landing in the same cycle,
  // so readers of the register being written take the data from here.
  always_comb begin
    byp_hit_a  = rf_write_en && (rf_write_reg == byp_reg_a);
    byp_hit_b  = rf_write_en && (rf_write_reg == byp_reg_b);
    byp_data_a = byp_hit_a ? rf_write_data : '0;
    byp_data_b = byp_hit_b ? rf_write_data : '0;
  end
`endif

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the execute stage (ALU results) and the memory stage (load data).
- Tracks pending destination registers in a 32-bit scoreboard so decode can stall on RAW hazards.
- Sits between the EX/MEM writeback paths and the regfile write port; its registered write outputs drive the regfile directly.

Parameters:
- DATA_W, 64, register data width.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of architectural registers.
- ZERO_REG, 31, index of XZR; writes to it are discarded.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute writeback request.
- ex_reg  in  ADDR_W  execute destination register.
- ex_data  in  DATA_W  execute result.
- ex_ready  out  1  execute request granted this cycle.
- mem_valid  in  1  memory writeback request.
- mem_reg  in  ADDR_W  memory destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  memory request granted this cycle.
- alloc_valid  in  1  decode issued an instruction with a destination register.
- alloc_reg  in  ADDR_W  destination to mark pending.
- flush  in  1  clears the scoreboard and arbitration priority.
- busy_mask  out  NUM_REGS  scoreboard; bit i set means register i has a pending write.
- rf_write_en  out  1  to regfile regWrite.
- rf_write_reg  out  ADDR_W  to regfile write_reg.
- rf_write_data  out  DATA_W  to regfile write_data.

Behaviour:
- Handshake: a transfer occurs when valid && ready. Once valid is raised, the requester holds valid, reg and data stable until ready. ready is combinational from the valid inputs and the priority state, and is never asserted without valid.
- Port usage: at most one grant per cycle.
- Priority FSM, states PRIO_EX and PRIO_MEM; reset state is PRIO_MEM.
  - When only one requester is valid, it is granted and the state is unchanged.
  - When both are valid, the favoured requester is granted and the state toggles to favour the other.
  - Consequence: each requester is granted within 2 cycles of asserting valid.
- Write stage: on a grant, rf_write_en, rf_write_reg and rf_write_data are registered, so the regfile sees the write one cycle after the handshake.
  - rf_write_en = 0 when the granted register is ZERO_REG; that handshake still completes.
  - rf_write_en deasserts on the next cycle without a grant.
- Scoreboard:
  - alloc_valid with alloc_reg != ZERO_REG sets that busy bit at the next edge.
  - A cycle with rf_write_en = 1 clears the bit for rf_write_reg at that edge.
  - Set and clear of the same bit in the same cycle: set wins, because a newer producer is outstanding.
  - busy_mask[ZERO_REG] is always 0.
  - Alloc of an already-busy register leaves it set; there is no counting.
- flush: clears busy_mask and returns the FSM to PRIO_MEM at the next edge. A write already registered in the write stage still commits. An alloc in the same cycle as flush is dropped. A grant in the same cycle as flush still proceeds.
- reset: all outputs 0, busy_mask 0, FSM PRIO_MEM. It takes effect at the next edge and overrides any handshake in flight. Requests pending during reset are re-presented by the requesters.
- Ordering: two in-flight writes to the same register are ordered by the pipeline, not by this block.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- When defined, adds the following ports:
  - byp_reg_a, byp_reg_b: in, ADDR_W.
  - byp_hit_a, byp_hit_b: out, 1.
  - byp_data_a, byp_data_b: out, DATA_W.
- Bypass logic: combinational compare against the write stage. hit = rf_write_en && (rf_write_reg == byp_reg). On a hit, data = rf_write_data; otherwise hit = 0 and data = 0.
- Purpose: covers the regfile's registered read of a register written the same cycle.
- When undefined, these ports do not exist and no compare logic is built.

Decomposition:
- definitions.vh gets:
  - ZERO_REG index, register count and data/address widths.
  - PRIO_EX / PRIO_MEM state encodings.
- Natural sub-module: rr_arbiter2. It takes two valid inputs, holds the priority state, and produces one-hot grants; it is reusable for other two-requester shared ports.
- The scoreboard and write stage stay in the top module.

Test Plan:
- Reset, then ex_valid alone with reg 5, data 0xDEAD → ex_ready=1 that cycle; next cycle rf_write_en=1, reg 5, data 0xDEAD.
- Both valid for 4 cycles (ex reg 1, mem reg 2, each dropping valid after its grant) → cycle 1 mem granted, cycle 2 ex granted; rf writes to reg 2 then reg 1.
- alloc reg 7 → busy_mask[7]=1 next cycle. Then mem write to reg 7 → bit 7 clears at the edge after rf_write_en. Alloc reg 7 in that same clear cycle → bit stays 1.
- ex write to reg 31, data 0x1 → ex_ready=1, rf_write_en stays 0. alloc reg 31 → busy_mask stays 0.
- busy bits 3 and 9 set, assert flush together with alloc of reg 4 → busy_mask=0 next cycle. Then reset asserted while both requesters are valid → no ready, all outputs 0 next cycle.
- With RF_WRITE_BYPASS_EN: grant ex reg 12, data 0x55; in the write-stage cycle byp_reg_a=12 → byp_hit_a=1, byp_data_a=0x55; byp_reg_b=13 → byp_hit_b=0.
